// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-requester burst arbiter for the shared ideal_mem port
module mem_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 4,
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]       req_len,
  input  logic [NUM_REQ*(ADDR_WIDTH-2)-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic                               rsp_last,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  output logic [ADDR_WIDTH-3:0]              mem_Waddr,
  output logic [ADDR_WIDTH-3:0]              mem_Raddr,
  output logic                               mem_Wren,
  output logic                               mem_Rden,
  output logic [DATA_WIDTH-1:0]              mem_Wdata,
  input  logic [DATA_WIDTH-1:0]              mem_Rdata
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int IW = $clog2(NUM_REQ);
  localparam int RL = READ_LATENCY;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, last_owner, sel, ack_o;
  logic [IW-1:0] po [RL];
  logic [RL-1:0] pv, pl;
  logic [AW-1:0] base, addr;
  logic [LEN_WIDTH-1:0] len, beat_cnt;
  logic wr, found, issue, ack_v, out_v, ack_out;
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic [AW-1:0] addr_a [NUM_REQ];
  logic [LEN_WIDTH-1:0] len_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign len_a[i]   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
  end
  // Mode 0 searches upward from last_owner+1 with wrap; mode 1 from index 0
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IW-1:0] c;
      c = PRIORITY_MODE != 0 ? IW'(k - 1) : IW'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req_valid[c]) begin
        sel = c;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = |req_valid ? BURST : IDLE;
    else if (state == BURST) state_n = issue && beat_cnt == len ? (wr ? IDLE : DRAIN) : BURST;
    else state_n = out_v && pl[RL-1] ? IDLE : DRAIN;
  end
  always_comb begin
    issue = state == BURST && req_valid[owner] && !rst;
    addr = base + AW'(beat_cnt);
    mem_Wren = issue && wr;
    mem_Rden = issue && !wr;
    mem_Waddr = mem_Wren ? addr : '0;
    mem_Raddr = mem_Rden ? addr : '0;
    mem_Wdata = mem_Wren ? wdata_a[owner] : '0;
    req_ready = issue ? NUM_REQ'(1) << owner : '0;
    out_v = pv[RL-1] && !rst;
    ack_out = ack_v && !rst;
    rsp_valid = (out_v ? NUM_REQ'(1) << po[RL-1] : '0) | (ack_out ? NUM_REQ'(1) << ack_o : '0);
    rsp_last = (out_v && pl[RL-1]) || ack_out;
    rsp_rdata = out_v ? mem_Rdata : '0;
    busy = state != IDLE && !rst;
    grant_id = rst ? '0 : owner;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      wr <= 1'b0;
      base <= '0;
      len <= '0;
      beat_cnt <= '0;
      ack_v <= 1'b0;
      ack_o <= '0;
      pv <= '0;
      pl <= '0;
    end else begin
      if (state == IDLE && found) begin
        owner <= sel;
        last_owner <= sel;
        wr <= req_write[sel];
        base <= addr_a[sel];
        len <= len_a[sel];
        beat_cnt <= '0;
      end else if (issue) beat_cnt <= beat_cnt + 1'b1;
      ack_v <= mem_Wren && beat_cnt == len;
      ack_o <= owner;
      pv <= (pv << 1) | RL'(mem_Rden);
      pl <= (pl << 1) | RL'(mem_Rden && beat_cnt == len);
    end
  end
  // Owner tags only matter where pv is set, so they need no reset
  always_ff @(posedge clk) begin
    po[0] <= owner;
    for (int i = 1; i < RL; i++) po[i] <= po[i-1];
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench, instance 0 round-robin/latency 1, instance 1 fixed/latency 3
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] rv [2], rw [2], rdy [2], rspv [2];
  logic [15:0] rl [2];
  logic [35:0] ra [2];
  logic [127:0] rwd [2];
  logic rlast [2], bsy [2], we [2], re [2];
  logic [31:0] rdat [2], wd [2], mrd [2];
  logic [1:0] gid [2];
  logic [8:0] wa [2], rad [2];
  logic [31:0] mem [512];
  int n_chk = 0, n_err = 0;
  typedef struct {logic [8:0] a; logic [31:0] v;} wr_t;
  typedef struct {int o; logic [31:0] v; logic l;} rsp_t;
  wr_t wq[$];
  rsp_t rq[$];
  logic [8:0] aq[$];
  int gq[$];

  task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int RL = g == 0 ? 1 : 3;
    logic [31:0] pd [3];
    logic pb = 1'b0;
    wr_t ew;
    rsp_t er;
    mem_port_arbiter #(.READ_LATENCY(RL), .PRIORITY_MODE(g)) dut (
      .clk(clk), .rst(rst), .req_valid(rv[g]), .req_write(rw[g]), .req_len(rl[g]),
      .req_addr(ra[g]), .req_wdata(rwd[g]), .req_ready(rdy[g]), .rsp_valid(rspv[g]),
      .rsp_last(rlast[g]), .rsp_rdata(rdat[g]), .grant_id(gid[g]), .busy(bsy[g]),
      .mem_Waddr(wa[g]), .mem_Raddr(rad[g]), .mem_Wren(we[g]), .mem_Rden(re[g]),
      .mem_Wdata(wd[g]), .mem_Rdata(mrd[g]));
    always @(posedge clk) begin
      pd[0] <= re[g] ? mem[rad[g]] : 32'h0;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
    assign mrd[g] = pd[RL-1];
    always @(negedge clk) begin
      if (!rst) begin
        if (we[g]) begin
          check("write_expected", wq.size() > 0, 1);
          if (wq.size() > 0) begin
            ew = wq.pop_front();
            check("waddr", wa[g], ew.a);
            check("wdata", wd[g], ew.v);
          end
        end
        if (re[g]) begin
          check("read_expected", aq.size() > 0, 1);
          if (aq.size() > 0) check("raddr", rad[g], aq.pop_front());
        end
        if (rspv[g] != 0) begin
          check("rsp_expected", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            er = rq.pop_front();
            check("rsp", {rspv[g], rlast[g], rdat[g]}, {4'(1) << er.o, er.l, er.v});
          end
        end
        if (bsy[g] && !pb) begin
          check("grant_expected", gq.size() > 0, 1);
          if (gq.size() > 0) check("grant_id", gid[g], gq.pop_front());
        end
      end
      pb = bsy[g];
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; rw[d] = '0; rl[d] = '0; ra[d] = '0; rwd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic zero_chk(string tag, int d);
    check(tag, {rdy[d], rspv[d], rlast[d], rdat[d], gid[d], bsy[d], wa[d], rad[d], we[d], re[d], wd[d]}, 0);
  endtask

  task automatic drained(string tag);
    check(tag, wq.size() + aq.size() + rq.size() + gq.size(), 0);
  endtask

  // One requester runs one burst; returns cycles of first/last beat and of rsp_last
  task automatic burst(input int d, input int r, input bit w, input int len, input logic [8:0] a,
                       input logic [31:0] seed, input int st_at, input int st_n,
                       output int cf, output int cl, output int crl);
    int b = 0, c = 0, st = st_n;
    bit done = 0;
    gq.push_back(r);
    for (int k = 0; k <= len; k++) begin
      logic [8:0] ak;
      ak = a + 9'(k);
      if (w) wq.push_back('{ak, seed + 32'(k)});
      else begin
        aq.push_back(ak);
        rq.push_back('{r, mem[ak], k == len});
      end
    end
    if (w) rq.push_back('{r, 32'h0, 1'b1});
    cf = -1; cl = -1; crl = -1;
    rw[d][r] = w;
    rl[d][r*4 +: 4] = 4'(len);
    ra[d][r*9 +: 9] = a;
    rwd[d][r*32 +: 32] = seed;
    rv[d][r] = 1'b1;
    while (!done && c < 64) begin
      @(negedge clk);
      if (rdy[d][r]) begin
        if (b == 0) cf = c;
        cl = c;
        b++;
      end
      if (!rv[d][r] && b <= len) check("stall_quiet", {rdy[d], we[d], re[d]}, 0);
      if (rlast[d]) begin
        crl = c;
        done = 1;
      end
      @(posedge clk);
      #1;
      c++;
      rwd[d][r*32 +: 32] = seed + 32'(b);
      if (b == st_at + 1 && st > 0) begin
        rv[d][r] = 1'b0;
        st--;
      end else rv[d][r] = b <= len;
    end
    check("burst_done", done, 1);
    check("idle_after", bsy[d], 0);
  endtask

  initial begin
    int cf, cl, crl;
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[9'h020] = 32'h11;
    mem[9'h021] = 32'h22;
    do_reset();
    @(negedge clk);
    zero_chk("reset_a", 0);
    zero_chk("reset_b", 1);
    @(posedge clk);
    #1;
    // Single write burst, exact timing
    burst(0, 0, 1, 3, 9'h010, 32'hA0, 0, 0, cf, cl, crl);
    check("t1_timing", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd4, 8'd5});
    drained("t1_drained");
    do_reset();
    burst(0, 2, 0, 1, 9'h020, 32'h0, 0, 0, cf, cl, crl);
    check("t2_timing", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd2, 8'd3});
    drained("t2_drained");
    // All four requesters hold single-beat writes: round-robin order
    do_reset();
    for (int n = 0; n < 5; n++) begin
      int i;
      i = n % 4;
      gq.push_back(i);
      wq.push_back('{9'(9'h040 + i), 32'hB0 + 32'(i)});
      rq.push_back('{i, 32'h0, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      ra[0][i*9 +: 9] = 9'(9'h040 + i);
      rwd[0][i*32 +: 32] = 32'hB0 + 32'(i);
    end
    rw[0] = 4'hF;
    rv[0] = 4'hF;
    repeat (10) @(posedge clk);
    #1 rv[0] = '0;
    repeat (4) @(posedge clk);
    drained("t3_rr");
    // Same traffic, fixed priority: requester 0 always wins
    do_reset();
    for (int n = 0; n < 3; n++) begin
      gq.push_back(0);
      wq.push_back('{9'h040, 32'hB0});
      rq.push_back('{0, 32'h0, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      ra[1][i*9 +: 9] = 9'(9'h040 + i);
      rwd[1][i*32 +: 32] = 32'hB0 + 32'(i);
    end
    rw[1] = 4'hF;
    rv[1] = 4'hF;
    repeat (6) @(posedge clk);
    #1 rv[1] = '0;
    repeat (4) @(posedge clk);
    drained("t3_fixed");
    // Address wrap
    do_reset();
    burst(0, 1, 0, 3, 9'h1FE, 32'h0, 0, 0, cf, cl, crl);
    check("t4_timing", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd4, 8'd5});
    drained("t4_drained");
    // Stall after beat 1 for two cycles
    do_reset();
    burst(0, 0, 1, 3, 9'h080, 32'hD0, 1, 2, cf, cl, crl);
    check("t5_timing", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd6, 8'd7});
    drained("t5_drained");
    // Latency-3 read burst
    do_reset();
    burst(1, 3, 0, 2, 9'h100, 32'h0, 0, 0, cf, cl, crl);
    check("lat3_timing", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd3, 8'd6});
    drained("lat3_drained");
    // Reset during a latency-3 read: pending responses must vanish
    do_reset();
    gq.push_back(0);
    aq.push_back(9'h030);
    aq.push_back(9'h031);
    rw[1][0] = 1'b0;
    rl[1][3:0] = 4'd3;
    ra[1][8:0] = 9'h030;
    rv[1][0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rv[1][0] = 1'b0;
    @(negedge clk);
    zero_chk("t6_in_reset", 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("t6_after_reset", 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_rsp", {rspv[1], rlast[1]}, 0);
    end
    @(posedge clk);
    #1;
    burst(1, 0, 1, 0, 9'h050, 32'hE0, 0, 0, cf, cl, crl);
    check("t6_regrant", {8'(cf), 8'(cl), 8'(crl)}, {8'd1, 8'd1, 8'd2});
    drained("t6_drained");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-requester arbiter for the shared ideal_mem port (Raddr2/Waddr/Wren/Rden2).
- Replaces the fixed OR-merge of request-select and DMA memory traffic.
- Supports round-robin or fixed priority, burst ownership, requester stall and configurable read latency.
- Sits between requesters (request select, DMA engine, future masters) and ideal_mem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 11, byte address width of ideal_mem; word address is ADDR_WIDTH-2 bits
DATA_WIDTH, 32, data width
LEN_WIDTH, 4, burst length field width; beats = len+1
READ_LATENCY, 1, cycles from mem_Rden to valid mem_Rdata (1..3)
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  request / beat-valid per requester
req_write  in  NUM_REQ  1 = write burst, 0 = read burst
req_len  in  NUM_REQ*LEN_WIDTH  beats-1, packed, requester i at [i*LEN_WIDTH +: LEN_WIDTH]
req_addr  in  NUM_REQ*(ADDR_WIDTH-2)  base word address, packed
req_wdata  in  NUM_REQ*DATA_WIDTH  current write beat data, packed
req_ready  out  NUM_REQ  beat accepted this cycle (owner only)
rsp_valid  out  NUM_REQ  read data valid, or write-complete ack
rsp_last  out  1  final response of the burst
rsp_rdata  out  DATA_WIDTH  read data (shared)
grant_id  out  $clog2(NUM_REQ)  current owner
busy  out  1  burst in progress (state != IDLE)
mem_Waddr  out  ADDR_WIDTH-2  write address
mem_Raddr  out  ADDR_WIDTH-2  read address
mem_Wren  out  1  write enable
mem_Rden  out  1  read enable
mem_Wdata  out  DATA_WIDTH  write data
mem_Rdata  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after mem_Rden

Behaviour:
- Clock and reset: the block runs on one clock, clk. rst is synchronous and active-high.
- Reset:
  - All outputs are 0 and state is IDLE.
  - Round-robin pointer last_owner = NUM_REQ-1, so requester 0 wins first.
  - The read response pipeline is flushed.
- States: IDLE, BURST, DRAIN.
- IDLE (arbitration cycle):
  - If any req_valid is set, select the owner. Mode 0: first set bit searching from last_owner+1 with wrap. Mode 1: lowest set index.
  - Latch owner, write flag, base address and len; clear beat_cnt; move to BURST.
  - No memory access occurs in this cycle. grant_id updates the following cycle.
- BURST:
  - A beat issues only in a cycle where req_valid[owner]=1. req_ready[owner]=1 combinationally in that cycle.
  - Beat address = base+beat_cnt modulo 2^(ADDR_WIDTH-2), i.e. wraps to 0.
  - Write beat: mem_Wren=1, mem_Waddr=address, mem_Wdata=owner's req_wdata slice.
  - Read beat: mem_Rden=1, mem_Raddr=address.
  - If req_valid[owner]=0: stall. No memory enable, beat_cnt holds, req_ready=0.
  - beat_cnt increments on each issued beat.
  - On the beat where beat_cnt==len: a write burst goes to IDLE; a read burst goes to DRAIN.
- Write ack: one cycle after the final write beat, rsp_valid[owner]=1 and rsp_last=1 for one cycle; rsp_rdata=0.
- Read response:
  - A READ_LATENCY-deep shift register carries {valid, last, owner} per read beat.
  - When an entry emerges: rsp_valid[owner]=1, rsp_rdata=mem_Rdata (pass-through), rsp_last=1 for the final beat only.
- DRAIN: wait until the last read response has emerged, then go to IDLE in the same cycle as rsp_last.
- Memory-side outputs are 0 whenever their enable is 0, so the port stays OR-combinable with other sources.
- Non-owners always see req_ready=0. New requests are ignored until IDLE.
- On grant, last_owner is updated to the new owner. A requester holding req_valid after completion re-arbitrates normally; in mode 0 it has lowest priority.
- Turnaround between bursts is at least one IDLE cycle. A write burst of L beats with no stalls occupies L+1 cycles.
- rst asserted mid-burst:
  - The burst aborts and the next cycle is IDLE.
  - All outputs are 0.
  - Pending read responses are discarded and never emitted.
- req_len, req_addr and req_write of the owner are sampled only in the grant cycle; later changes are ignored.

Test Plan:
1. Default params, req0 write len=3 addr=0x010 data 0xA0..0xA3 at cycle 0 -> grant cycle 0; Wren cycles 1-4, addr 0x010..0x013, req_ready[0] cycles 1-4; rsp_valid[0]+rsp_last cycle 5; busy 0 cycle 6.
2. req2 read len=1 addr=0x020, memory holds 0x11,0x22, READ_LATENCY=1 -> Rden cycles 1-2; rsp_valid[2] cycles 2-3 with data 0x11 then 0x22; rsp_last only cycle 3.
3. All four requesters hold single-beat writes continuously: mode 0 -> grant order 0,1,2,3,0; mode 1 -> always 0, others starve.
4. Read base 0x1FE len=3 (ADDR_WIDTH=11) -> mem_Raddr 0x1FE, 0x1FF, 0x000, 0x001.
5. Write len=3 with req_valid[0] dropped for 2 cycles after beat 1 -> no Wren and req_ready=0 in those cycles; beats 2-3 resume at addresses base+2, base+3; exactly 4 writes total.
6. READ_LATENCY=3, rst pulsed after the 2nd read beat -> next cycle all outputs 0, busy 0; no rsp_valid ever emitted for that burst; a subsequent req0 is granted normally.
